// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between requesters A and B.
// Round-robin ownership with bounded bursts. At most one RAM access per clock.
// A tag pipe routes each read's returning data to the requester that issued it.
module ram_port_arbiter #(
  parameter int MEM_WIDTH  = 16,
  parameter int ADD_SIZE   = 10,
  parameter int RD_LATENCY = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADD_SIZE-1:0]  a_addr,
  input  logic [MEM_WIDTH-1:0] a_wdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADD_SIZE-1:0]  b_addr,
  input  logic [MEM_WIDTH-1:0] b_wdata,
  output logic                 a_gnt,
  output logic                 b_gnt,
  output logic                 a_rvalid,
  output logic                 b_rvalid,
  output logic [MEM_WIDTH-1:0] a_rdata,
  output logic [MEM_WIDTH-1:0] b_rdata,
  output logic                 a_rparity,
  output logic                 b_rparity,
  output logic                 ram_blk_select,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic                 ram_addr_en,
  output logic                 ram_dout_en,
  output logic [ADD_SIZE-1:0]  ram_addr,
  output logic [MEM_WIDTH-1:0] ram_din,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_parity
);

  // A single-beat burst still needs one counter bit.
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   burst_cnt_reg;
  logic               rr_ptr_reg;       // 0 = A wins a tie next, 1 = B
  logic               addr_en_reg;
  logic [RD_LATENCY-1:0] tag_valid_reg;
  logic [RD_LATENCY-1:0] tag_owner_reg; // 1 = read belongs to B

  logic own_a;
  logic own_b;
  logic beat;
  logic owner_we;
  logic burst_last;

  assign own_a      = (state_reg == OWN_A);
  assign own_b      = (state_reg == OWN_B);
  assign a_gnt      = own_a && a_req;
  assign b_gnt      = own_b && b_req;
  assign beat       = a_gnt || b_gnt;
  assign owner_we   = own_b ? b_we : a_we;
  assign burst_last = (burst_cnt_reg == CNT_W'(MAX_BURST - 1));

  // RAM command is a pure mux of the current owner's held command.
  assign ram_blk_select = beat;
  assign ram_wr_en      = beat && owner_we;
  assign ram_rd_en      = beat && !owner_we;
  assign ram_addr       = beat ? (own_b ? b_addr  : a_addr)  : '0;
  assign ram_din        = beat ? (own_b ? b_wdata : a_wdata) : '0;
  assign ram_addr_en    = addr_en_reg;
  assign ram_dout_en    = addr_en_reg;

  // The last tag stage lines up with the RAM presenting that read's data.
  assign a_rvalid  = tag_valid_reg[RD_LATENCY-1] && !tag_owner_reg[RD_LATENCY-1];
  assign b_rvalid  = tag_valid_reg[RD_LATENCY-1] &&  tag_owner_reg[RD_LATENCY-1];
  assign a_rdata   = ram_dout;
  assign b_rdata   = ram_dout;
  assign a_rparity = ram_parity;
  assign b_rparity = ram_parity;

  // Ownership FSM: pick an owner from IDLE, count burst beats, hand over on release or burst end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      burst_cnt_reg <= '0;
      rr_ptr_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (a_req && b_req) state_reg <= rr_ptr_reg ? OWN_B : OWN_A;
          else if (a_req)     state_reg <= OWN_A;
          else if (b_req)     state_reg <= OWN_B;
        end
        OWN_A: begin
          if (a_req) begin
            if (burst_last) begin
              burst_cnt_reg <= '0;
              rr_ptr_reg    <= 1'b1;
              if (b_req) state_reg <= OWN_B;
            end else begin
              burst_cnt_reg <= burst_cnt_reg + 1'b1;
            end
          end else begin
            burst_cnt_reg <= '0;
            rr_ptr_reg    <= 1'b1;
            state_reg     <= b_req ? OWN_B : IDLE;
          end
        end
        OWN_B: begin
          if (b_req) begin
            if (burst_last) begin
              burst_cnt_reg <= '0;
              rr_ptr_reg    <= 1'b0;
              if (a_req) state_reg <= OWN_A;
            end else begin
              burst_cnt_reg <= burst_cnt_reg + 1'b1;
            end
          end else begin
            burst_cnt_reg <= '0;
            rr_ptr_reg    <= 1'b0;
            state_reg     <= a_req ? OWN_A : IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          burst_cnt_reg <= '0;
        end
      endcase
    end
  end

  // RAM pipeline enables free-run once reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_en_reg <= 1'b0;
    else     addr_en_reg <= 1'b1;
  end

  // Read tag pipe: stage 0 captures each beat, later stages just shift.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        // Load valid only for read beats; writes and bubbles push an empty tag.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            tag_valid_reg[0] <= 1'b0;
            tag_owner_reg[0] <= 1'b0;
          end else begin
            tag_valid_reg[0] <= ram_rd_en;
            tag_owner_reg[0] <= own_b;
          end
        end
      end else begin : g_body
        // Shift the tag one stage toward the output.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_owner_reg[gi] <= 1'b0;
          end else begin
            tag_valid_reg[gi] <= tag_valid_reg[gi-1];
            tag_owner_reg[gi] <= tag_owner_reg[gi-1];
          end
        end
      end
    end
  endgenerate

endmodule
